// File: rtl/avalon_arbiter.sv
// Two-master round-robin arbiter in front of a single Avalon-MM slave.
// One transfer in flight at a time: the winning request is latched, presented
// to the slave until accepted, then completed to its master for one cycle.
module avalon_arbiter #(
  parameter int unsigned ADDR_WIDTH = 24
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  // master 0
  input  logic                  i_AV0_Read,
  input  logic                  i_AV0_Write,
  input  logic [ADDR_WIDTH-1:0] i_AV0_Addr,
  input  logic [31:0]           i_AV0_WriteData,
  input  logic [3:0]            i_AV0_ByteEnable,
  output logic [31:0]           o_AV0_ReadData,
  output logic                  o_AV0_WaitRequest,
  // master 1
  input  logic                  i_AV1_Read,
  input  logic                  i_AV1_Write,
  input  logic [ADDR_WIDTH-1:0] i_AV1_Addr,
  input  logic [31:0]           i_AV1_WriteData,
  input  logic [3:0]            i_AV1_ByteEnable,
  output logic [31:0]           o_AV1_ReadData,
  output logic                  o_AV1_WaitRequest,
  // slave
  output logic                  o_S_Read,
  output logic                  o_S_Write,
  output logic [ADDR_WIDTH-1:0] o_S_Addr,
  output logic [31:0]           o_S_WriteData,
  output logic [3:0]            o_S_ByteEnable,
  input  logic [31:0]           i_S_ReadData,
  input  logic                  i_S_WaitRequest
);

  typedef enum logic [1:0] {StIdle, StIssue, StRdata, StWdone} state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;   // master owning the current transfer
  logic                  last_q, last_d;     // master served most recently
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;

  logic pend0, pend1, sel, done;

  // State and latched-request registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;  // master 0 wins the first tie
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Arbitration and transfer sequencing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    pend0   = i_AV0_Read | i_AV0_Write;
    pend1   = i_AV1_Read | i_AV1_Write;
    sel     = (pend0 && pend1) ? ~last_q : pend1;
    unique case (state_q)
      StIdle: begin
        if (pend0 || pend1) begin
          state_d = StIssue;
          grant_d = sel;
          // Read+Write together is treated as a plain read.
          rd_d    = sel ? i_AV1_Read : i_AV0_Read;
          wr_d    = sel ? (i_AV1_Write & ~i_AV1_Read) : (i_AV0_Write & ~i_AV0_Read);
          addr_d  = sel ? i_AV1_Addr : i_AV0_Addr;
          wdata_d = sel ? i_AV1_WriteData : i_AV0_WriteData;
          be_d    = sel ? i_AV1_ByteEnable : i_AV0_ByteEnable;
        end
      end
      StIssue: begin
        if (!i_S_WaitRequest) state_d = rd_q ? StRdata : StWdone;
      end
      StRdata, StWdone: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Slave-side strobes only in ISSUE; master completion only in RDATA/WDONE.
  always_comb begin
    done              = (state_q == StRdata) || (state_q == StWdone);
    o_S_Read          = (state_q == StIssue) & rd_q;
    o_S_Write         = (state_q == StIssue) & wr_q;
    o_S_Addr          = addr_q;
    o_S_WriteData     = wdata_q;
    o_S_ByteEnable    = be_q;
    o_AV0_WaitRequest = !(done && !grant_q);
    o_AV1_WaitRequest = !(done && grant_q);
    o_AV0_ReadData    = (state_q == StRdata && !grant_q) ? i_S_ReadData : 32'h0;
    o_AV1_ReadData    = (state_q == StRdata && grant_q) ? i_S_ReadData : 32'h0;
  end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Directed bench for avalon_arbiter: per-cycle vector table plus hand-written
// sequences for slave stall and reset during an outstanding transfer.
module tb_avalon_arbiter;

  localparam int unsigned AW = 24;

  typedef struct {
    logic          rst;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    logic [3:0]    be0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [31:0]   d1;
    logic [3:0]    be1;
    logic          swait;
    logic [31:0]   srd;
  } in_t;

  typedef struct {
    logic          rd, wr, bus;  // bus: also compare addr/wdata/be
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [3:0]    be;
    logic          w0, w1;
    logic [31:0]   d0, d1;
  } exp_t;

  typedef struct {
    in_t  stim;
    exp_t want;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          r0, w0, r1, w1, swait;
  logic [AW-1:0] a0, a1;
  logic [31:0]   d0, d1, srd;
  logic [3:0]    be0, be1;
  logic [31:0]   o_d0, o_d1, o_wd;
  logic          o_w0, o_w1, o_rd, o_wr;
  logic [AW-1:0] o_addr;
  logic [3:0]    o_be;

  int n_vec = 0;
  int n_err = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  avalon_arbiter #(.ADDR_WIDTH(AW)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_AV0_Read(r0), .i_AV0_Write(w0), .i_AV0_Addr(a0), .i_AV0_WriteData(d0),
    .i_AV0_ByteEnable(be0), .o_AV0_ReadData(o_d0), .o_AV0_WaitRequest(o_w0),
    .i_AV1_Read(r1), .i_AV1_Write(w1), .i_AV1_Addr(a1), .i_AV1_WriteData(d1),
    .i_AV1_ByteEnable(be1), .o_AV1_ReadData(o_d1), .o_AV1_WaitRequest(o_w1),
    .o_S_Read(o_rd), .o_S_Write(o_wr), .o_S_Addr(o_addr), .o_S_WriteData(o_wd),
    .o_S_ByteEnable(o_be), .i_S_ReadData(srd), .i_S_WaitRequest(swait)
  );

  function automatic in_t mk_in(logic rst, logic ir0, logic iw0, logic [AW-1:0] ia0,
                                logic [31:0] id0, logic [3:0] ibe0, logic ir1, logic iw1,
                                logic [AW-1:0] ia1, logic [31:0] id1, logic [3:0] ibe1,
                                logic isw, logic [31:0] isr);
    in_t v;
    v.rst = rst; v.r0 = ir0; v.w0 = iw0; v.a0 = ia0; v.d0 = id0; v.be0 = ibe0;
    v.r1 = ir1; v.w1 = iw1; v.a1 = ia1; v.d1 = id1; v.be1 = ibe1;
    v.swait = isw; v.srd = isr;
    return v;
  endfunction

  function automatic exp_t e_done(logic ew0, logic ew1, logic [31:0] ed0, logic [31:0] ed1);
    exp_t e;
    e.rd = 1'b0; e.wr = 1'b0; e.bus = 1'b0; e.addr = '0; e.wd = '0; e.be = '0;
    e.w0 = ew0; e.w1 = ew1; e.d0 = ed0; e.d1 = ed1;
    return e;
  endfunction

  function automatic exp_t e_idle();
    return e_done(1'b1, 1'b1, 32'h0, 32'h0);
  endfunction

  // Reset values: strobes low, bus zero, both masters stalled.
  function automatic exp_t e_rst();
    exp_t e;
    e = e_idle();
    e.bus = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_iss(logic erd, logic ewr, logic [AW-1:0] ea, logic [31:0] ewd,
                                 logic [3:0] ebe);
    exp_t e;
    e = e_idle();
    e.rd = erd; e.wr = ewr; e.bus = 1'b1; e.addr = ea; e.wd = ewd; e.be = ebe;
    return e;
  endfunction

  task automatic add(input in_t s, input exp_t e);
    vec_t v;
    v.stim = s;
    v.want = e;
    vq.push_back(v);
  endtask

  task automatic drive(input in_t s);
    rst_n = ~s.rst;
    r0 = s.r0; w0 = s.w0; a0 = s.a0; d0 = s.d0; be0 = s.be0;
    r1 = s.r1; w1 = s.w1; a1 = s.a1; d1 = s.d1; be1 = s.be1;
    swait = s.swait; srd = s.srd;
  endtask

  task automatic chk(input string nm, input exp_t e);
    logic ok;
    n_vec++;
    ok = (o_rd === e.rd) && (o_wr === e.wr) && (o_w0 === e.w0) && (o_w1 === e.w1) &&
         (o_d0 === e.d0) && (o_d1 === e.d1) &&
         (!e.bus || ((o_addr === e.addr) && (o_wd === e.wd) && (o_be === e.be)));
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got rd=%b wr=%b addr=%h wd=%h be=%h w0=%b w1=%b d0=%h d1=%h ; want rd=%b wr=%b addr=%h wd=%h be=%h (bus chk %b) w0=%b w1=%b d0=%h d1=%h",
               nm, o_rd, o_wr, o_addr, o_wd, o_be, o_w0, o_w1, o_d0, o_d1,
               e.rd, e.wr, e.addr, e.wd, e.be, e.bus, e.w0, e.w1, e.d0, e.d1);
    end
  endtask

  initial begin
    exp_t e;
    // single M0 read, slave data one cycle after acceptance
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h5, 32'h0, 4'hF, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 32'h0),
        e_idle());
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h5, 32'h0, 4'hF, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 32'h0),
        e_iss(1'b1, 1'b0, 24'h5, 32'h0, 4'hF));
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h5, 32'h0, 4'hF, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0,
              32'h11000137), e_done(1'b0, 1'b1, 32'h11000137, 32'h0));
    add(mk_in(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 32'h0),
        e_idle());
    // reset restores the pointer so M0 wins the next tie
    add(mk_in(1'b1, 1'b1, 1'b0, 24'h7, 32'h0, 4'hF, 1'b1, 1'b0, 24'h9, 32'h0, 4'hF, 1'b0, 32'h0),
        e_rst());
    // tie: M0 first, then strict alternation with held requests
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h7, 32'h0, 4'hF, 1'b1, 1'b0, 24'h9, 32'h0, 4'hF, 1'b0, 32'h0),
        e_idle());
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h7, 32'h0, 4'hF, 1'b1, 1'b0, 24'h9, 32'h0, 4'hF, 1'b0, 32'h0),
        e_iss(1'b1, 1'b0, 24'h7, 32'h0, 4'hF));
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h7, 32'h0, 4'hF, 1'b1, 1'b0, 24'h9, 32'h0, 4'hF, 1'b0,
              32'hA0A0A0A0), e_done(1'b0, 1'b1, 32'hA0A0A0A0, 32'h0));
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h20, 32'h0, 4'hF, 1'b1, 1'b0, 24'h9, 32'h0, 4'hF, 1'b0, 32'h0),
        e_idle());
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h20, 32'h0, 4'hF, 1'b1, 1'b0, 24'h9, 32'h0, 4'hF, 1'b0, 32'h0),
        e_iss(1'b1, 1'b0, 24'h9, 32'h0, 4'hF));
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h20, 32'h0, 4'hF, 1'b1, 1'b0, 24'h9, 32'h0, 4'hF, 1'b0,
              32'hB1B1B1B1), e_done(1'b1, 1'b0, 32'h0, 32'hB1B1B1B1));
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h20, 32'h0, 4'hF, 1'b1, 1'b0, 24'h21, 32'h0, 4'hF, 1'b0, 32'h0),
        e_idle());
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h20, 32'h0, 4'hF, 1'b1, 1'b0, 24'h21, 32'h0, 4'hF, 1'b0, 32'h0),
        e_iss(1'b1, 1'b0, 24'h20, 32'h0, 4'hF));
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h20, 32'h0, 4'hF, 1'b1, 1'b0, 24'h21, 32'h0, 4'hF, 1'b0,
              32'hC2C2C2C2), e_done(1'b0, 1'b1, 32'hC2C2C2C2, 32'h0));
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h20, 32'h0, 4'hF, 1'b1, 1'b0, 24'h21, 32'h0, 4'hF, 1'b0, 32'h0),
        e_idle());
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h20, 32'h0, 4'hF, 1'b1, 1'b0, 24'h21, 32'h0, 4'hF, 1'b0, 32'h0),
        e_iss(1'b1, 1'b0, 24'h21, 32'h0, 4'hF));
    add(mk_in(1'b0, 1'b1, 1'b0, 24'h20, 32'h0, 4'hF, 1'b1, 1'b0, 24'h21, 32'h0, 4'hF, 1'b0,
              32'hD3D3D3D3), e_done(1'b1, 1'b0, 32'h0, 32'hD3D3D3D3));
    add(mk_in(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 32'h0),
        e_idle());
    // Read+Write together on M0 becomes a read
    add(mk_in(1'b0, 1'b1, 1'b1, 24'h30, 32'h55, 4'hF, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 32'h0),
        e_idle());
    add(mk_in(1'b0, 1'b1, 1'b1, 24'h30, 32'h55, 4'hF, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 32'h0),
        e_iss(1'b1, 1'b0, 24'h30, 32'h55, 4'hF));
    add(mk_in(1'b0, 1'b1, 1'b1, 24'h30, 32'h55, 4'hF, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0,
              32'hE4E4E4E4), e_done(1'b0, 1'b1, 32'hE4E4E4E4, 32'h0));
    // M0 write: no read data returned in WDONE
    add(mk_in(1'b0, 1'b0, 1'b1, 24'h40, 32'h12345678, 4'hC, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0,
              32'h0), e_idle());
    add(mk_in(1'b0, 1'b0, 1'b1, 24'h40, 32'h12345678, 4'hC, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0,
              32'h0), e_iss(1'b0, 1'b1, 24'h40, 32'h12345678, 4'hC));
    add(mk_in(1'b0, 1'b0, 1'b1, 24'h40, 32'h12345678, 4'hC, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0,
              32'hFFFFFFFF), e_done(1'b0, 1'b1, 32'h0, 32'h0));
    add(mk_in(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 32'h0),
        e_idle());

    // power-on reset with requests present
    drive(mk_in(1'b0, 1'b1, 1'b0, 24'h3, 32'h1, 4'hF, 1'b0, 1'b1, 24'h4, 32'h2, 4'hF, 1'b0,
                32'h99));
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("por", e_rst());

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].stim);
      #1 chk($sformatf("vec%0d", k), vq[k].want);
    end

    // slave stall on M1 write; master inputs change but latched bus must not
    @(negedge clk);
    drive(mk_in(1'b1, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 32'h0));
    @(negedge clk);
    drive(mk_in(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 1'b1, 24'h10, 32'hDEADBEEF, 4'h3,
                1'b1, 32'h0));
    #1 chk("stall_idle", e_idle());
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      swait = (k < 4);
      if (k > 0) begin
        a1 = 24'h100 + 24'(k);
        d1 = 32'h0BAD0000 + 32'(k);
        be1 = 4'hF;
      end
      #1 chk($sformatf("stall_issue%0d", k), e_iss(1'b0, 1'b1, 24'h10, 32'hDEADBEEF, 4'h3));
    end
    @(negedge clk);
    srd = 32'h77777777;
    #1 chk("stall_wdone", e_done(1'b1, 1'b0, 32'h0, 32'h0));
    @(negedge clk);
    w1 = 1'b0;
    #1 chk("stall_back_idle", e_idle());

    // reset during ISSUE of an M0 read aborts it silently
    @(negedge clk);
    drive(mk_in(1'b0, 1'b1, 1'b0, 24'h77, 32'h0, 4'hF, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 32'h0));
    #1 chk("abort_idle", e_idle());
    @(negedge clk);
    #1 chk("abort_issue", e_iss(1'b1, 1'b0, 24'h77, 32'h0, 4'hF));
    #2 rst_n = 1'b0;
    #1 chk("abort_rst_now", e_rst());
    @(posedge clk);
    #1 chk("abort_rst_edge", e_rst());
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_resume_idle", e_idle());
    @(negedge clk);
    #1 chk("abort_resume_issue", e_iss(1'b1, 1'b0, 24'h77, 32'h0, 4'hF));
    @(negedge clk);
    srd = 32'h600DF00D;
    #1 chk("abort_resume_rdata", e_done(1'b0, 1'b1, 32'h600DF00D, 32'h0));
    @(negedge clk);
    r0 = 1'b0;
    e = e_idle();
    #1 chk("abort_resume_done", e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_arbiter.md
AVALON_ARBITER -- requirements
Module: avalon_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, word-address width of both master ports and the slave port.
REQ-002 SHALL have input i_Clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have input i_Rst_n, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have, for each master m in {0,1}, the following master-facing signals:
- input i_AVm_Read, 1 bit, read request.
- input i_AVm_Write, 1 bit, write request.
- input i_AVm_Addr, ADDR_WIDTH bits, word address.
- input i_AVm_WriteData, 32 bits, write data.
- input i_AVm_ByteEnable, 4 bits, byte lanes.
- output o_AVm_ReadData, 32 bits, read data.
- output o_AVm_WaitRequest, 1 bit, stall.
REQ-005 SHALL have the following slave-facing signals:
- output o_S_Read, 1 bit.
- output o_S_Write, 1 bit.
- output o_S_Addr, ADDR_WIDTH bits.
- output o_S_WriteData, 32 bits.
- output o_S_ByteEnable, 4 bits.
- input i_S_ReadData, 32 bits; the slave returns data exactly 1 cycle after an accepted read.
- input i_S_WaitRequest, 1 bit.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, RDATA, WDONE, plus a 1-bit grant register g and a 1-bit last-served pointer p.
REQ-007 In IDLE, a master m is pending when i_AVm_Read or i_AVm_Write is 1.
REQ-008 In IDLE, if exactly one master is pending, the FSM SHALL grant it.
REQ-009 In IDLE, if both masters are pending, the FSM SHALL grant master (~p), i.e. round-robin.
REQ-010 In IDLE, if no master is pending, the FSM SHALL stay in IDLE.
REQ-011 On a grant, the FSM SHALL enter ISSUE, set g to the granted master, and latch that master's Read, Write, Addr, WriteData and ByteEnable.
REQ-012 In ISSUE, o_S_* SHALL be driven from the latched values; in every other state o_S_Read=0 and o_S_Write=0.
REQ-013 In ISSUE, while i_S_WaitRequest=1 the FSM SHALL hold in ISSUE with the latched values unchanged.
REQ-014 In ISSUE, when i_S_WaitRequest=0 the transfer is accepted: the FSM SHALL go to RDATA for a read, or to WDONE for a write.
REQ-015 If a master asserts Read and Write together, the arbiter SHALL treat the request as a read and SHALL keep o_S_Write=0.
REQ-016 In RDATA, o_AVg_ReadData SHALL equal i_S_ReadData (combinational) and o_AVg_WaitRequest SHALL be 0.
REQ-017 In WDONE, o_AVg_WaitRequest SHALL be 0.
REQ-018 Both RDATA and WDONE SHALL last exactly 1 cycle, then set p to g and return to IDLE.
REQ-019 o_AVm_WaitRequest SHALL be 1 at all other times, including when master m is idle.
REQ-020 o_AVm_ReadData SHALL be 0 except for the granted master in RDATA.
REQ-021 Latency SHALL be: a read issued into IDLE with a zero-wait slave completes on the 3rd rising edge (IDLE, ISSUE, RDATA); a write also completes in 3 cycles (IDLE, ISSUE, WDONE).
REQ-022 A master keeps its request asserted through its completion cycle. That held request SHALL NOT be re-granted: arbitration is evaluated only in IDLE, after the master has seen WaitRequest=0 and is expected to deassert or issue a new transfer.
REQ-023 A request from the non-granted master during ISSUE, RDATA or WDONE SHALL be held off (WaitRequest=1) and considered at the next IDLE.
REQ-024 Under back-to-back requests from both masters, grants SHALL strictly alternate 0,1,0,1; no master waits more than one other transfer.

Reset
REQ-025 While i_Rst_n=0, asynchronously:
- FSM=IDLE, g=0, p=1 (master 0 wins the first tie);
- all latched request registers cleared;
- o_S_Read=0, o_S_Write=0, o_S_Addr=0, o_S_WriteData=0, o_S_ByteEnable=0;
- o_AV0_WaitRequest=o_AV1_WaitRequest=1;
- o_AV0_ReadData=o_AV1_ReadData=0.
REQ-026 Reset asserted in ISSUE, RDATA or WDONE SHALL abort the transfer with no completion signalled to any master.
REQ-027 Operation SHALL resume in IDLE on the first rising edge after i_Rst_n rises.

Verification
REQ-028 Single read: M0 reads Addr=5, slave returns 0x11000137 one cycle after acceptance -> o_AV0_ReadData=0x11000137 with o_AV0_WaitRequest=0 on cycle 3; o_AV1_WaitRequest=1 throughout.
REQ-029 Tie: both masters read at the same edge after reset -> M0 served first, M1 completes 3 cycles later; continuous requests thereafter -> alternating grants 0,1,0,1.
REQ-030 Slave stall: M1 writes 0xDEADBEEF, ByteEnable=0x3, Addr=0x10, with i_S_WaitRequest=1 for 4 cycles -> o_S_Write, o_S_Addr, o_S_WriteData and o_S_ByteEnable stable for 5 cycles, then WDONE, o_AV1_WaitRequest=0 for 1 cycle.
REQ-031 Illegal Read+Write on M0 -> o_S_Read=1, o_S_Write=0; data returned as a read.
REQ-032 Reset pulse during ISSUE of an M0 read -> all outputs at reset values immediately; no WaitRequest=0 pulse to M0; a subsequent M0 read completes normally in 3 cycles.
